// File: rtl/pc_sequencer.sv
// Multicycle control sequencer and program counter feeding the fetch stage.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and redirects pc on taken branches.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FETCH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        need_mem,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  input  logic        mem_done,
  output logic [2:0]  state,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        retire,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_RSVD   = 3'd5,
    ST_IDLE   = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  localparam logic [3:0] FETCH_LAST = 4'(FETCH_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  fetch_cnt_reg, fetch_cnt_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] next_pc_reg, next_pc_next;
  logic [31:0] ir_reg, ir_next;
  logic [31:0] count_reg, count_next;
  logic        retire_reg, retire_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      fetch_cnt_reg <= 4'd0;
      pc_reg        <= RESET_PC;
      next_pc_reg   <= RESET_PC;
      ir_reg        <= 32'd0;
      count_reg     <= 32'd0;
      retire_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fetch_cnt_reg <= fetch_cnt_next;
      pc_reg        <= pc_next;
      next_pc_reg   <= next_pc_next;
      ir_reg        <= ir_next;
      count_reg     <= count_next;
      retire_reg    <= retire_next;
    end
  end

  // The fetch counter defaults to zero so it is already clear on every entry to FETCH.
  always_comb begin
    state_next     = state_reg;
    fetch_cnt_next = 4'd0;
    pc_next        = pc_reg;
    next_pc_next   = next_pc_reg;
    ir_next        = ir_reg;
    count_next     = count_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetch_cnt_reg == FETCH_LAST) begin
          ir_next    = instr;
          state_next = ST_DECODE;
        end else begin
          fetch_cnt_next = fetch_cnt_reg + 4'd1;
        end
      end
      ST_DECODE: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (halt) begin
          state_next = ST_HALT;
        end else begin
          next_pc_next = branch_taken ? {branch_target[31:2], 2'b00} : pc_reg + 32'd4;
          state_next   = need_mem ? ST_MEM : ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_done) state_next = ST_WB;
      end
      ST_WB: begin
        pc_next    = next_pc_reg;
        count_next = count_reg + 32'd1;
        state_next = ST_FETCH;
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Registered so retire is high exactly while state reads WB.
  assign retire_next = (state_next == ST_WB);

  assign state       = state_reg;
  assign pc          = pc_reg;
  assign ir          = ir_reg;
  assign retire      = retire_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; retirements are checked against a scoreboard of expected
// {pc, ir, count} records pushed when each instruction is driven.
module tb_pc_sequencer;

  localparam int FC = 2;

  logic        clk;
  logic        rst, rst2;
  logic        start;
  logic [31:0] instr;
  logic        need_mem, branch_taken, halt, mem_done;
  logic [31:0] branch_target;

  logic [2:0]  state1, state2;
  logic [31:0] pc1, pc2, ir1, ir2, cnt1, cnt2;
  logic        retire1, retire2;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_count = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] cnt;
  } rec_t;
  rec_t sb[$];

  pc_sequencer #(.RESET_PC(32'h0000_0000), .FETCH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .need_mem(need_mem),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .mem_done(mem_done), .state(state1), .pc(pc1), .ir(ir1), .retire(retire1),
    .instr_count(cnt1)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .FETCH_CYCLES(FC)) dut_wrap (
    .clk(clk), .rst(rst2), .start(start), .instr(instr), .need_mem(need_mem),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .mem_done(mem_done), .state(state2), .pc(pc2), .ir(ir2), .retire(retire2),
    .instr_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cyc(input string tag, input logic [2:0] exp_state, input logic [31:0] exp_pc);
    chk({tag, ".state"}, 32'(state1), 32'(exp_state));
    chk({tag, ".pc"}, pc1, exp_pc);
    chk({tag, ".retire"}, 32'(retire1), 32'(exp_state == 3'd4));
  endtask

  // Called at the negedge of the first FETCH cycle; returns at the negedge after WB (or in HALT).
  task automatic run_instr(input string tag, input logic [31:0] exp_pc, input logic [31:0] word,
                           input int mem_cycles, input logic br, input logic [31:0] tgt,
                           input logic hlt);
    if (!hlt) sb.push_back('{exp_pc, word, model_count});
    for (int i = 0; i < FC; i++) begin
      cyc({tag, ".fetch"}, 3'd0, exp_pc);
      instr = (i == FC - 1) ? word : 32'hDEAD_BEEF;
      tick();
    end
    instr = 32'hDEAD_BEEF;
    cyc({tag, ".decode"}, 3'd1, exp_pc);
    chk({tag, ".ir"}, ir1, word);
    tick();
    cyc({tag, ".exec"}, 3'd2, exp_pc);
    halt          = hlt;
    need_mem      = (mem_cycles > 0);
    branch_taken  = br;
    branch_target = tgt;
    tick();
    halt = 1'b0; need_mem = 1'b0; branch_taken = 1'b0;
    if (hlt) begin
      cyc({tag, ".halt"}, 3'd7, exp_pc);
      chk({tag, ".halt_cnt"}, cnt1, model_count);
      return;
    end
    for (int i = 0; i < mem_cycles; i++) begin
      cyc({tag, ".mem"}, 3'd3, exp_pc);
      mem_done = (i == mem_cycles - 1);
      tick();
    end
    mem_done = 1'b0;
    cyc({tag, ".wb"}, 3'd4, exp_pc);
    chk({tag, ".wb_cnt"}, cnt1, model_count);
    tick();
    model_count = model_count + 32'd1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && retire1 === 1'b1) begin
      chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        rec_t r;
        r = sb.pop_front();
        chk("retire.pc", pc1, r.pc);
        chk("retire.ir", ir1, r.ir);
        chk("retire.cnt", cnt1, r.cnt);
        $display("retire pc=%h ir=%h count=%0d", pc1, ir1, cnt1);
      end
    end
  end

  initial begin
    rst = 1'b0; rst2 = 1'b0; start = 1'b0; instr = 32'd0;
    need_mem = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    halt = 1'b0; mem_done = 1'b0;

    repeat (2) tick();
    cyc("rst", 3'd6, 32'd0);
    chk("rst.ir", ir1, 32'd0);
    chk("rst.cnt", cnt1, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      cyc("idle", 3'd6, 32'd0);
      chk("idle.ir", ir1, 32'd0);
      chk("idle.cnt", cnt1, 32'd0);
    end

    start = 1'b1; tick(); start = 1'b0;
    run_instr("alu0", 32'h0, 32'h0000_0013, 0, 1'b0, 32'h0, 1'b0);
    run_instr("alu1", 32'h4, 32'h0000_0013, 0, 1'b0, 32'h0, 1'b0);
    run_instr("alu2", 32'h8, 32'h0000_0013, 0, 1'b0, 32'h0, 1'b0);
    chk("alu.cnt3", cnt1, 32'd3);
    $display("alu: three instructions retired, pc=%h", pc1);

    run_instr("load", 32'hC, 32'h0000_2083, 3, 1'b0, 32'h0, 1'b0);
    run_instr("br_t", 32'h10, 32'h0000_0063, 0, 1'b1, 32'h0000_0103, 1'b0);
    run_instr("br_nt", 32'h100, 32'h0000_0063, 0, 1'b0, 32'h0000_0103, 1'b0);
    cyc("after_br", 3'd0, 32'h104);
    chk("after_br.cnt", cnt1, 32'd6);

    // Abort while waiting in MEM: reset acts between clock edges.
    cyc("abort.fetch", 3'd0, 32'h104); instr = 32'h0000_2083; tick();
    cyc("abort.fetch", 3'd0, 32'h104); tick();
    cyc("abort.decode", 3'd1, 32'h104); tick();
    cyc("abort.exec", 3'd2, 32'h104); need_mem = 1'b1; tick();
    need_mem = 1'b0;
    cyc("abort.mem", 3'd3, 32'h104); tick();
    cyc("abort.mem", 3'd3, 32'h104);
    #1 rst = 1'b0;
    #1;
    cyc("abort.rst", 3'd6, 32'd0);
    chk("abort.ir", ir1, 32'd0);
    chk("abort.cnt", cnt1, 32'd0);
    $display("abort: reset in MEM, state=%0d pc=%h count=%0d", state1, pc1, cnt1);
    tick(); rst = 1'b1; model_count = 32'd0;
    tick();
    cyc("abort.idle", 3'd6, 32'd0);

    start = 1'b1; tick(); start = 1'b0;
    run_instr("post", 32'h0, 32'h0000_0093, 0, 1'b0, 32'h0, 1'b0);
    run_instr("halt", 32'h4, 32'h0010_0073, 0, 1'b0, 32'h0, 1'b1);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cyc("halted", 3'd7, 32'h4);
      chk("halted.cnt", cnt1, 32'd1);
    end
    start = 1'b0;

    rst2 = 1'b1; instr = 32'h0000_0013;
    tick();
    chk("wrap.idle", 32'(state2), 32'd6);
    chk("wrap.rstpc", pc2, 32'hFFFF_FFFC);
    start = 1'b1; tick(); start = 1'b0;
    chk("wrap.fetchpc", pc2, 32'hFFFF_FFFC);
    repeat (FC + 3) tick();
    chk("wrap.state", 32'(state2), 32'd0);
    chk("wrap.pc", pc2, 32'd0);
    chk("wrap.cnt", cnt2, 32'd1);
    $display("wrap: pc=%h count=%0d", pc2, cnt2);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
